quiz_buzz_arbiter: RTL and testbench

Front-end arbiter for the quiz-buzzer board. It synchronises and debounces the host button and the contestant buttons, then decides who buzzed first or who fouled. It produces the one-cycle `start` and `finish` pulses consumed by the 5-second countdown/7-segment stage, and drives the winner LEDs. It sits directly upstream of the countdown stage on the same 100 MHz `clk`.

---
 rtl/quiz_buzz_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_quiz_buzz_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_buzz_arbiter.sv
// quiz_buzz_arbiter
//   Front end of the quiz-buzzer board. Every button (host + contestants) is
//   synchronised and debounced independently. A five-state FSM decides who
//   buzzed first or who fouled. It emits one-cycle start/finish pulses for the
//   countdown stage and drives the winner LEDs.
//
// Ports
//   clk          : system clock (100 MHz)
//   rst          : synchronous, active-high reset
//   host_btn     : raw host button, asynchronous, active-high
//   player_btn   : raw contestant buttons [N_PLAYERS], asynchronous, active-high
//   start        : 1-cycle pulse, arm / restart the countdown
//   finish       : 1-cycle pulse, a valid answer arrived
//   winner_id    : index of the latched contestant (qualified by winner_valid)
//   winner_valid : high in ANSWERED or FOUL
//   foul         : high in FOUL
//   timeout      : high in TIMEOUT
//   led          : one-hot winner LED, 0 unless winner_valid
module quiz_buzz_arbiter #(
  parameter int N_PLAYERS       = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int WINDOW_CYCLES   = 500_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         host_btn,
  input  logic [N_PLAYERS-1:0]         player_btn,
  output logic                         start,
  output logic                         finish,
  output logic [$clog2(N_PLAYERS)-1:0] winner_id,
  output logic                         winner_valid,
  output logic                         foul,
  output logic                         timeout,
  output logic [N_PLAYERS-1:0]         led
);

  localparam int ID_W = $clog2(N_PLAYERS);
  localparam int NB   = N_PLAYERS + 1;              // host is the top bit
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ANSWERED,
    S_FOUL,
    S_TIMEOUT
  } state_t;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   btn_sync_p0;
  logic [NB-1:0]   btn_sync_p1;
  logic [NB-1:0]   btn_stable;
  logic [NB-1:0]   btn_stable_d;
  logic [NB-1:0]   btn_press;
  logic [DB_W-1:0] db_cnt [NB];

  logic                 host_ev;
  logic [N_PLAYERS-1:0] player_ev;
  logic                 any_player;
  logic [ID_W-1:0]      first_id;

  state_t          state, state_nxt;
  logic [31:0]     win_cnt, win_cnt_nxt;
  logic            start_nxt, finish_nxt;
  logic [ID_W-1:0] id_nxt;
  logic            valid_nxt, foul_nxt, timeout_nxt;
  logic [N_PLAYERS-1:0] led_nxt;

  assign btn_raw = {host_btn, player_btn};

  // Stage p0/p1: two-flop synchroniser, then per-button debounce.
  // The debounce counter only runs while the synchronised level disagrees
  // with the accepted level, so any bounce back to the stable level restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_p0  <= '0;
      btn_sync_p1  <= '0;
      btn_stable   <= '0;
      btn_stable_d <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      btn_sync_p0  <= btn_raw;
      btn_sync_p1  <= btn_sync_p0;
      btn_stable_d <= btn_stable;
      for (int i = 0; i < NB; i++) begin
        if (btn_sync_p1[i] == btn_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_stable[i] <= ~btn_stable[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Rising edge of the accepted level; releases produce nothing.
  assign btn_press  = btn_stable & ~btn_stable_d;
  assign host_ev    = btn_press[NB-1];
  assign player_ev  = btn_press[N_PLAYERS-1:0];
  assign any_player = |player_ev;

  // Lowest index wins simultaneous presses.
  always_comb begin
    first_id = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (player_ev[i]) first_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    start_nxt   = 1'b0;
    finish_nxt  = 1'b0;
    id_nxt      = winner_id;

    case (state)
      S_IDLE: begin
        if (any_player) begin
          state_nxt = S_FOUL;
          id_nxt    = first_id;
        end else if (host_ev) begin
          state_nxt   = S_ARMED;
          start_nxt   = 1'b1;
          win_cnt_nxt = '0;
        end
      end
      S_ARMED: begin
        win_cnt_nxt = win_cnt + 32'd1;
        // A player press beats both a host re-arm and the window expiry.
        if (any_player) begin
          state_nxt  = S_ANSWERED;
          finish_nxt = 1'b1;
          id_nxt     = first_id;
        end else if (host_ev) begin
          start_nxt   = 1'b1;
          win_cnt_nxt = '0;
        end else if (win_cnt == 32'(WINDOW_CYCLES - 1)) begin
          state_nxt = S_TIMEOUT;
        end
      end
      S_ANSWERED, S_FOUL, S_TIMEOUT: begin
        if (host_ev) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    valid_nxt   = (state_nxt == S_ANSWERED) || (state_nxt == S_FOUL);
    foul_nxt    = (state_nxt == S_FOUL);
    timeout_nxt = (state_nxt == S_TIMEOUT);
    led_nxt     = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      led_nxt[i] = valid_nxt && (id_nxt == ID_W'(i));
    end
  end

  // Stage p2: state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      win_cnt      <= '0;
      start        <= 1'b0;
      finish       <= 1'b0;
      winner_id    <= '0;
      winner_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
      led          <= '0;
    end else begin
      state        <= state_nxt;
      win_cnt      <= win_cnt_nxt;
      start        <= start_nxt;
      finish       <= finish_nxt;
      winner_id    <= id_nxt;
      winner_valid <= valid_nxt;
      foul         <= foul_nxt;
      timeout      <= timeout_nxt;
      led          <= led_nxt;
    end
  end

endmodule

// File: tb/tb_quiz_buzz_arbiter.sv
module tb_quiz_buzz_arbiter;

  localparam int NP = 4;
  localparam int DB = 4;
  localparam int WN = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_btn;
  logic [NP-1:0] player_btn;
  logic          start, finish, winner_valid, foul, timeout;
  logic [1:0]    winner_id;
  logic [NP-1:0] led;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_start  = 0;
  int n_finish = 0;

  quiz_buzz_arbiter #(
    .N_PLAYERS      (NP),
    .DEBOUNCE_CYCLES(DB),
    .WINDOW_CYCLES  (WN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_btn    (host_btn),
    .player_btn  (player_btn),
    .start       (start),
    .finish      (finish),
    .winner_id   (winner_id),
    .winner_valid(winner_valid),
    .foul        (foul),
    .timeout     (timeout),
    .led         (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          host;
    logic [NP-1:0] pl;
    int            cycles;
    int            n_start;
    int            n_finish;
    logic          wv;
    logic [1:0]    wid;
    logic          fl;
    logic          to;
    logic [NP-1:0] led;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (start === 1'b1) n_start++;
    if (finish === 1'b1) n_finish++;
    if (start === 1'b1 && finish === 1'b1) chk("start_finish_overlap", 32'd1, 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_outs(input string nm, input logic wv, input logic [1:0] wid,
                          input logic fl, input logic to, input logic [NP-1:0] l);
    chk({nm, "_valid"},   32'(winner_valid), 32'(wv));
    chk({nm, "_id"},      32'(winner_id),    32'(wid));
    chk({nm, "_foul"},    32'(foul),         32'(fl));
    chk({nm, "_timeout"}, 32'(timeout),      32'(to));
    chk({nm, "_led"},     32'(led),          32'(l));
  endtask

  // Press the host until a start pulse appears; returns the cycle it was seen.
  task automatic arm(input string nm, output int s);
    int n0;
    bit seen;
    n0 = n_start;
    seen = 0;
    s = cyc;
    host_btn = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (n_start != n0) begin
        seen = 1;
        s = cyc;
      end
    end
    chk({nm, "_start_seen"}, 32'(seen), 32'd1);
    host_btn = 1'b0;
  endtask

  task automatic host_to_idle();
    host_btn = 1'b1;
    ticks(10);
    host_btn = 1'b0;
    ticks(10);
  endtask

  initial begin
    int s, s2, ns, nf;

    //            host  pl       cyc st fin wv wid fl to  led
    vecs[0]  = '{1'b0, 4'b0100, 10, 0, 1, 1, 2'd2, 0, 0, 4'b0100};
    vecs[1]  = '{1'b0, 4'b0000, 10, 0, 0, 1, 2'd2, 0, 0, 4'b0100};
    vecs[2]  = '{1'b0, 4'b0001, 10, 0, 0, 1, 2'd2, 0, 0, 4'b0100};
    vecs[3]  = '{1'b0, 4'b0000, 10, 0, 0, 1, 2'd2, 0, 0, 4'b0100};
    vecs[4]  = '{1'b1, 4'b0000, 10, 0, 0, 0, 2'd2, 0, 0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0000, 10, 0, 0, 0, 2'd2, 0, 0, 4'b0000};
    vecs[6]  = '{1'b1, 4'b0000, 10, 1, 0, 0, 2'd2, 0, 0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0000, 10, 0, 0, 0, 2'd2, 0, 0, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0001,  3, 0, 0, 0, 2'd2, 0, 0, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0000, 10, 0, 0, 0, 2'd2, 0, 0, 4'b0000};
    vecs[10] = '{1'b0, 4'b1010, 10, 0, 1, 1, 2'd1, 0, 0, 4'b0010};
    vecs[11] = '{1'b0, 4'b0000, 10, 0, 0, 1, 2'd1, 0, 0, 4'b0010};
    vecs[12] = '{1'b1, 4'b0000, 10, 0, 0, 0, 2'd1, 0, 0, 4'b0000};
    vecs[13] = '{1'b0, 4'b0000, 10, 0, 0, 0, 2'd1, 0, 0, 4'b0000};
    vecs[14] = '{1'b0, 4'b1000, 10, 0, 0, 1, 2'd3, 1, 0, 4'b1000};
    vecs[15] = '{1'b0, 4'b0000, 10, 0, 0, 1, 2'd3, 1, 0, 4'b1000};
    vecs[16] = '{1'b1, 4'b0000, 10, 0, 0, 0, 2'd3, 0, 0, 4'b0000};
    vecs[17] = '{1'b0, 4'b0000, 10, 0, 0, 0, 2'd3, 0, 0, 4'b0000};

    rst = 1'b1;
    host_btn = 1'b0;
    player_btn = '0;
    ticks(3);
    chk("reset_start",  32'(start),  32'd0);
    chk("reset_finish", 32'(finish), 32'd0);
    chk_outs("reset", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0;

    // Host press latency: sampled at the next edge, pulse visible 6 edges later.
    host_btn = 1'b1;
    ns = n_start;
    ticks(6);
    chk("arm_start_early", 32'(n_start - ns), 32'd0);
    tick();
    chk("arm_start_edge", 32'(start), 32'd1);
    tick();
    chk("arm_start_width", 32'(start), 32'd0);
    ticks(2);
    host_btn = 1'b0;
    ticks(10);
    chk("arm_start_count", 32'(n_start - ns), 32'd1);
    chk("arm_finish", 32'(n_finish), 32'd0);
    chk_outs("armed", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);

    for (int v = 0; v < 18; v++) begin
      ns = n_start;
      nf = n_finish;
      host_btn   = vecs[v].host;
      player_btn = vecs[v].pl;
      ticks(vecs[v].cycles);
      chk($sformatf("vec%0d_start", v),  32'(n_start - ns),  32'(vecs[v].n_start));
      chk($sformatf("vec%0d_finish", v), 32'(n_finish - nf), 32'(vecs[v].n_finish));
      chk_outs($sformatf("vec%0d", v), vecs[v].wv, vecs[v].wid, vecs[v].fl,
               vecs[v].to, vecs[v].led);
    end
    host_btn = 1'b0;
    player_btn = '0;

    // Timeout exactly WN cycles after the start pulse.
    nf = n_finish;
    arm("to", s);
    while (cyc < s + WN - 1) tick();
    chk("to_before", 32'(timeout), 32'd0);
    tick();
    chk("to_at", 32'(timeout), 32'd1);
    chk("to_no_finish", 32'(n_finish - nf), 32'd0);
    chk_outs("to", 1'b0, 2'd3, 1'b0, 1'b1, 4'b0000);
    host_to_idle();
    chk("to_cleared", 32'(timeout), 32'd0);

    // Player event in the expiry cycle wins over the timeout.
    arm("late", s);
    nf = n_finish;
    while (cyc < s + WN - 7) tick();
    player_btn = 4'b0001;
    ticks(6);
    chk("late_finish_early", 32'(n_finish - nf), 32'd0);
    tick();
    chk("late_finish", 32'(finish), 32'd1);
    chk_outs("late", 1'b1, 2'd0, 1'b0, 1'b0, 4'b0001);
    player_btn = '0;
    ticks(10);
    host_to_idle();

    // Re-arm half way restarts the window.
    arm("rearm1", s);
    while (cyc < s + 43) tick();
    arm("rearm2", s2);
    chk("rearm_cycle", 32'(s2 - s), 32'd50);
    while (cyc < s2 + WN - 1) tick();
    chk("rearm_to_before", 32'(timeout), 32'd0);
    tick();
    chk("rearm_to_at", 32'(timeout), 32'd1);
    host_to_idle();

    // Reset while armed with player 1 held, then it debounces into a foul.
    arm("rst", s);
    player_btn = 4'b0010;
    ticks(3);
    rst = 1'b1;
    ns = n_start;
    nf = n_finish;
    tick();
    rst = 1'b0;
    chk("rst_start",  32'(start),  32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk_outs("rst", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    ticks(12);
    chk_outs("rst_foul", 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010);
    chk("rst_pulses", 32'((n_start - ns) + (n_finish - nf)), 32'd0);
    player_btn = '0;
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
